// File: rtl/lcd_hd44780_responder_if.sv
// LCD panel bus as seen between an HD44780-style driver and the panel.
interface lcd_hd44780_responder_if;
    logic [7:0] LCD_DATA;
    logic       LCD_RW;
    logic       LCD_EN;
    logic       LCD_RS;

    // Driver side of the bus
    modport master (output LCD_DATA, output LCD_RW, output LCD_EN, output LCD_RS);
    // Panel side of the bus
    modport slave  (input  LCD_DATA, input  LCD_RW, input  LCD_EN, input  LCD_RS);
endinterface

// File: rtl/lcd_hd44780_responder.sv
// Cycle-based HD44780 16x2 panel responder: decodes bus writes into a
// 32-character visible image, models busy timing and flags protocol abuse.
module lcd_hd44780_responder #(
    parameter int unsigned CMD_BUSY   = 2000,
    parameter int unsigned CLEAR_BUSY = 76000
) (
    input  logic                          iCLK,
    input  logic                          iRST_N,
    lcd_hd44780_responder_if.slave        lcd,
    input  logic [4:0]                    iRD_ADDR,
    output logic [7:0]                    oRD_DATA,
    output logic                          oWR_STB,
    output logic [4:0]                    oWR_IDX,
    output logic [7:0]                    oWR_CHAR,
    output logic                          oBUSY,
    output logic                          oDISP_ON,
    output logic                          oFUNC_OK,
    output logic                          oBUSY_VIOL,
    output logic                          oERR
);
    localparam int unsigned BUSY_MAX = (CMD_BUSY > CLEAR_BUSY) ? CMD_BUSY : CLEAR_BUSY;
    localparam int unsigned CNT_W    = $clog2(BUSY_MAX + 1);
    localparam int unsigned IMG_N    = 32;

    typedef enum logic [1:0] {ST_CLEAR, ST_BUSY, ST_IDLE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       sweep_q, sweep_d;
    logic [6:0]       ac_q, ac_d;
    logic             id_q, id_d;
    logic             cg_q, cg_d;
    logic             en_q, en_d;
    logic             rs_q, rs_d;
    logic             rw_q, rw_d;
    logic [7:0]       data_q, data_d;
    logic             busy_q, busy_d;
    logic             disp_q, disp_d;
    logic             func_q, func_d;
    logic             viol_q, viol_d;
    logic             err_q, err_d;
    logic             wr_stb_q, wr_stb_d;
    logic [4:0]       wr_idx_q, wr_idx_d;
    logic [7:0]       wr_char_q, wr_char_d;
    logic [7:0]       rd_q;

    logic [7:0]       img_q [IMG_N];
    logic             img_we;
    logic [4:0]       img_waddr;
    logic [7:0]       img_wdata;

    logic             strobe;
    logic             start_busy;
    logic             addr_ok;

    // Address counter step with the line1/line2 wrap points of a 2-line panel
    function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
        if (inc) begin
            if (ac == 7'h27)      ac_step = 7'h40;
            else if (ac == 7'h67) ac_step = 7'h00;
            else                  ac_step = 7'(ac + 7'd1);
        end else begin
            if (ac == 7'h40)      ac_step = 7'h27;
            else if (ac == 7'h00) ac_step = 7'h67;
            else                  ac_step = 7'(ac - 7'd1);
        end
    endfunction

    assign strobe  = en_q & ~lcd.LCD_EN;
    // Both lines share the same 0x00-0x27 column range; bit 6 selects the line
    assign addr_ok = (data_q[5:0] <= 6'h27);

    // Next-state, decode and image-write control
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sweep_d    = sweep_q;
        ac_d       = ac_q;
        id_d       = id_q;
        cg_d       = cg_q;
        en_d       = lcd.LCD_EN;
        rs_d       = rs_q;
        rw_d       = rw_q;
        data_d     = data_q;
        busy_d     = busy_q;
        disp_d     = disp_q;
        func_d     = func_q;
        viol_d     = viol_q;
        err_d      = err_q;
        wr_stb_d   = 1'b0;
        wr_idx_d   = wr_idx_q;
        wr_char_d  = wr_char_q;
        img_we     = 1'b0;
        img_waddr  = sweep_q;
        img_wdata  = 8'h20;
        start_busy = 1'b0;

        if (lcd.LCD_EN) begin
            rs_d   = lcd.LCD_RS;
            rw_d   = lcd.LCD_RW;
            data_d = lcd.LCD_DATA;
        end

        if (strobe && busy_q) viol_d = 1'b1;

        unique case (state_q)
            ST_CLEAR: begin
                img_we  = 1'b1;
                sweep_d = 5'(sweep_q + 5'd1);
                cnt_d   = cnt_q - CNT_W'(1);
                if (sweep_q == 5'd31) begin
                    ac_d    = 7'h00;
                    id_d    = 1'b1;
                    cg_d    = 1'b0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (strobe) begin
                    if (rw_q) begin
                        err_d = 1'b1;
                    end else if (rs_q) begin
                        if (!cg_q && (ac_q[5:4] == 2'b00)) begin
                            img_we    = 1'b1;
                            img_waddr = {ac_q[6], ac_q[3:0]};
                            img_wdata = data_q;
                            wr_stb_d  = 1'b1;
                            wr_idx_d  = {ac_q[6], ac_q[3:0]};
                            wr_char_d = data_q;
                        end
                        ac_d       = ac_step(ac_q, id_q);
                        start_busy = 1'b1;
                    end else begin
                        casez (data_q)
                            8'b1???????: begin
                                if (addr_ok) begin
                                    ac_d = data_q[6:0];
                                    cg_d = 1'b0;
                                end else begin
                                    err_d = 1'b1;
                                end
                                start_busy = 1'b1;
                            end
                            8'b01??????: begin
                                cg_d       = 1'b1;
                                start_busy = 1'b1;
                            end
                            8'b001?????: begin
                                func_d     = data_q[4] & data_q[3];
                                start_busy = 1'b1;
                            end
                            8'b0001????: start_busy = 1'b1;
                            8'b00001???: begin
                                disp_d     = data_q[2];
                                start_busy = 1'b1;
                            end
                            8'b000001??: begin
                                id_d       = data_q[1];
                                start_busy = 1'b1;
                            end
                            8'b0000001?: begin
                                ac_d       = 7'h00;
                                start_busy = 1'b1;
                            end
                            8'b00000001: begin
                                state_d = ST_CLEAR;
                                sweep_d = 5'd0;
                                busy_d  = 1'b1;
                                cnt_d   = CNT_W'(CLEAR_BUSY);
                            end
                            default: ;
                        endcase
                    end
                    if (start_busy) begin
                        state_d = ST_BUSY;
                        busy_d  = 1'b1;
                        cnt_d   = CNT_W'(CMD_BUSY);
                    end
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    // State and output registers
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q   <= ST_CLEAR;
            cnt_q     <= CNT_W'(CLEAR_BUSY);
            sweep_q   <= 5'd0;
            ac_q      <= 7'h00;
            id_q      <= 1'b1;
            cg_q      <= 1'b0;
            en_q      <= 1'b0;
            rs_q      <= 1'b0;
            rw_q      <= 1'b0;
            data_q    <= 8'h00;
            busy_q    <= 1'b1;
            disp_q    <= 1'b0;
            func_q    <= 1'b0;
            viol_q    <= 1'b0;
            err_q     <= 1'b0;
            wr_stb_q  <= 1'b0;
            wr_idx_q  <= 5'd0;
            wr_char_q <= 8'h00;
            rd_q      <= 8'h00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sweep_q   <= sweep_d;
            ac_q      <= ac_d;
            id_q      <= id_d;
            cg_q      <= cg_d;
            en_q      <= en_d;
            rs_q      <= rs_d;
            rw_q      <= rw_d;
            data_q    <= data_d;
            busy_q    <= busy_d;
            disp_q    <= disp_d;
            func_q    <= func_d;
            viol_q    <= viol_d;
            err_q     <= err_d;
            wr_stb_q  <= wr_stb_d;
            wr_idx_q  <= wr_idx_d;
            wr_char_q <= wr_char_d;
            rd_q      <= img_q[iRD_ADDR];
        end
    end

    // Character image storage; the reset sweep initialises it
    always_ff @(posedge iCLK) begin
        if (img_we) img_q[img_waddr] <= img_wdata;
    end

    assign oRD_DATA   = rd_q;
    assign oWR_STB    = wr_stb_q;
    assign oWR_IDX    = wr_idx_q;
    assign oWR_CHAR   = wr_char_q;
    assign oBUSY      = busy_q;
    assign oDISP_ON   = disp_q;
    assign oFUNC_OK   = func_q;
    assign oBUSY_VIOL = viol_q;
    assign oERR       = err_q;
endmodule
